// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM duty ramp controller: state encoding, default parameters
// and the clamped ramp step helper. The DEAD state exists only with PWM_RAMP_DEADTIME_EN.
package pwm_ramp_pkg;

   localparam int DEF_DC_WIDTH  = 8;
   localparam int DEF_RAMP_STEP = 4;
   localparam int DEF_RAMP_DIV  = 1;

`ifdef PWM_RAMP_DEADTIME_EN
   localparam int DEF_DEADTIME_PERIODS = 2;
   typedef enum logic [2:0] {ST_IDLE, ST_RAMP, ST_HOLD, ST_REV_DN, ST_DEAD} ramp_state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_RAMP, ST_HOLD, ST_REV_DN} ramp_state_t;
`endif

   // Move cur toward tgt by at most step. Landing exactly on tgt keeps the result
   // inside [min(cur,tgt), max(cur,tgt)], so the duty can never wrap.
   function automatic logic [31:0] ramp_step(input logic [31:0] cur,
                                             input logic [31:0] tgt,
                                             input logic [31:0] step);
      if (tgt > cur)
         return ((tgt - cur) <= step) ? tgt : (cur + step);
      else
         return ((cur - tgt) <= step) ? tgt : (cur - step);
   endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_period_tick.sv
// PWM period counter and ramp-step divider: PERIOD_TICK is high while the counter
// sits at all ones, and the step strobe fires on every RAMP_DIV-th tick.
module pwm_period_tick #(
   parameter int DC_WIDTH = 8,
   parameter int RAMP_DIV = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_div_clr,
   output logic o_period_tick,
   output logic o_step
);

   localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DC_WIDTH-1:0] CNT_PRE_WRAP = {{(DC_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [DIV_W-1:0]    DIV_LAST     = DIV_W'(RAMP_DIV - 1);

   logic [DC_WIDTH-1:0] r_cnt;
   logic                r_tick;
   logic [DIV_W-1:0]    r_div;

   // The tick is registered one count early so that it is low straight out of reset
   // even though the counter restarts at all ones.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt  <= '1;
         r_tick <= 1'b0;
         r_div  <= '0;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
         r_tick <= (r_cnt == CNT_PRE_WRAP);
         if (i_div_clr)
            r_div <= '0;
         else if (r_tick)
            r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      end
   end

   assign o_period_tick = r_tick;
   assign o_step        = r_tick & (r_div == DIV_LAST);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty/direction sequencer for the H-bridge PWM generator: slews DUTY toward the commanded
// target once per step, ramps through zero on reversal. Macro PWM_RAMP_DEADTIME_EN adds DEAD.
module pwm_ramp_ctrl
   import pwm_ramp_pkg::*;
#(
   parameter int PWM_DC_WIDTH = DEF_DC_WIDTH,
   parameter int RAMP_STEP    = DEF_RAMP_STEP,
   parameter int RAMP_DIV     = DEF_RAMP_DIV
`ifdef PWM_RAMP_DEADTIME_EN
   ,parameter int DEADTIME_PERIODS = DEF_DEADTIME_PERIODS
`endif
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [PWM_DC_WIDTH-1:0] i_tgt_dc,
   input  logic                    i_tgt_dir,
   input  logic                    i_tgt_vld,
   output logic                    o_tgt_rdy,
   input  logic                    i_estop,
   output logic [PWM_DC_WIDTH-1:0] o_duty,
   output logic                    o_dir,
   output logic                    o_en,
   output logic                    o_busy,
   output logic                    o_period_tick
);

`ifdef PWM_RAMP_DEADTIME_EN
   localparam int DEAD_W = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_PERIODS - 1);
   logic [DEAD_W-1:0] r_dead, w_dead_next;
`endif

   ramp_state_t             r_state, w_state_next;
   logic [PWM_DC_WIDTH-1:0] r_duty, w_duty_next;
   logic                    r_dir, w_dir_next;
   logic [PWM_DC_WIDTH-1:0] r_tgt_dc;
   logic                    r_tgt_dir;
   logic                    r_acc;
   logic                    r_live;
   logic                    w_tick, w_step, w_div_clr, w_accept, w_rev;
   logic [PWM_DC_WIDTH-1:0] w_stepped, w_stepped_dn;

   pwm_period_tick #(
      .DC_WIDTH (PWM_DC_WIDTH),
      .RAMP_DIV (RAMP_DIV)
   ) u_period_tick (
      .i_clk         (i_clk),
      .i_rst         (i_reset),
      .i_div_clr     (w_div_clr),
      .o_period_tick (w_tick),
      .o_step        (w_step)
   );

   assign w_stepped    = PWM_DC_WIDTH'(ramp_step(32'(r_duty), 32'(r_tgt_dc), 32'(RAMP_STEP)));
   assign w_stepped_dn = PWM_DC_WIDTH'(ramp_step(32'(r_duty), 32'd0, 32'(RAMP_STEP)));

   // A zero-duty target never needs a reversal: it just ramps down with DIR unchanged.
   assign w_rev     = (r_tgt_dir != r_dir) && (r_tgt_dc != '0);
   assign w_accept  = i_tgt_vld & o_tgt_rdy;
   assign w_div_clr = (w_state_next != r_state) &&
                      ((w_state_next == ST_RAMP) || (w_state_next == ST_REV_DN));

   always_comb begin
      w_state_next = r_state;
      w_duty_next  = r_duty;
      w_dir_next   = r_dir;
`ifdef PWM_RAMP_DEADTIME_EN
      w_dead_next  = r_dead;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_tick && (r_tgt_dc != '0)) begin
               w_dir_next   = r_tgt_dir;
               w_state_next = ST_RAMP;
            end
         end
         ST_RAMP: begin
            if (w_rev) begin
               w_state_next = ST_REV_DN;
            end else if (w_step) begin
               w_duty_next = w_stepped;
               if (w_stepped == r_tgt_dc)
                  w_state_next = (r_tgt_dc != '0) ? ST_HOLD : ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (r_acc)
               w_state_next = w_rev ? ST_REV_DN : ST_RAMP;
         end
         ST_REV_DN: begin
            if (w_step) begin
               w_duty_next = w_stepped_dn;
               if (w_stepped_dn == '0) begin
`ifdef PWM_RAMP_DEADTIME_EN
                  w_state_next = ST_DEAD;
                  w_dead_next  = '0;
`else
                  w_dir_next   = ~r_dir;
                  w_state_next = ST_RAMP;
`endif
               end
            end
         end
`ifdef PWM_RAMP_DEADTIME_EN
         ST_DEAD: begin
            if (w_tick) begin
               if (r_dead == DEAD_LAST) begin
                  w_dir_next   = ~r_dir;
                  w_state_next = ST_RAMP;
               end else begin
                  w_dead_next = r_dead + 1'b1;
               end
            end
         end
`endif
         default: w_state_next = ST_IDLE;
      endcase
      // Emergency stop overrides everything, including the tick alignment of DUTY.
      if (i_estop) begin
         w_state_next = ST_IDLE;
         w_duty_next  = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= ST_IDLE;
         r_duty    <= '0;
         r_dir     <= 1'b0;
         r_tgt_dc  <= '0;
         r_tgt_dir <= 1'b0;
         r_acc     <= 1'b0;
         r_live    <= 1'b0;
`ifdef PWM_RAMP_DEADTIME_EN
         r_dead    <= '0;
`endif
      end else begin
         r_live  <= 1'b1;
         r_state <= w_state_next;
         r_duty  <= w_duty_next;
         r_dir   <= w_dir_next;
`ifdef PWM_RAMP_DEADTIME_EN
         r_dead  <= w_dead_next;
`endif
         if (i_estop) begin
            r_tgt_dc  <= '0;
            r_tgt_dir <= 1'b0;
            r_acc     <= 1'b0;
         end else begin
            r_acc <= w_accept;
            if (w_accept) begin
               r_tgt_dc  <= i_tgt_dc;
               r_tgt_dir <= i_tgt_dir;
            end
         end
      end
   end

   assign o_tgt_rdy     = r_live & ~i_estop &
                          ((r_state == ST_IDLE) || (r_state == ST_RAMP) || (r_state == ST_HOLD));
   assign o_duty        = r_duty;
   assign o_dir         = r_dir;
   assign o_en          = (r_duty != '0) || (r_state == ST_RAMP) || (r_state == ST_REV_DN);
`ifdef PWM_RAMP_DEADTIME_EN
   assign o_busy        = (r_state == ST_RAMP) || (r_state == ST_REV_DN) || (r_state == ST_DEAD);
`else
   assign o_busy        = (r_state == ST_RAMP) || (r_state == ST_REV_DN);
`endif
   assign o_period_tick = w_tick;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus random commands, every
// cycle compared against a period-level reference model of the duty sequencer.
module tb_pwm_ramp_ctrl;

   localparam int W      = 8;
   localparam int STEP   = 4;
   localparam int PERIOD = 256;
   localparam int M_IDLE = 0, M_RAMP = 1, M_HOLD = 2, M_REV = 3, M_DEAD = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] tgt_dc;
   logic         tgt_dir, tgt_vld, tgt_rdy, estop;
   logic [W-1:0] duty;
   logic         dir, en, busy, period_tick;

   always #5 clk = ~clk;

   pwm_ramp_ctrl dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_tgt_dc      (tgt_dc),
      .i_tgt_dir     (tgt_dir),
      .i_tgt_vld     (tgt_vld),
      .o_tgt_rdy     (tgt_rdy),
      .i_estop       (estop),
      .o_duty        (duty),
      .o_dir         (dir),
      .o_en          (en),
      .o_busy        (busy),
      .o_period_tick (period_tick)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: m_n counts clock edges since reset release; a period boundary is
   // every PERIOD-th edge. All duty arithmetic is plain integer min/max.
   int m_n, m_duty, m_dir, m_tgt, m_tgt_dir, m_mode, m_acc, m_dead_left;
   int g_min_duty;
   bit g_saw_hold80;

   task automatic model_reset();
      m_n = 0; m_duty = 0; m_dir = 0; m_tgt = 0; m_tgt_dir = 0;
      m_mode = M_IDLE; m_acc = 0; m_dead_left = 0;
   endtask

   function automatic bit m_tick_now();
      return (m_n >= PERIOD) && ((m_n % PERIOD) == 0);
   endfunction

   function automatic bit m_rdy(input bit es);
      return (m_n >= 1) && !es && (m_mode == M_IDLE || m_mode == M_RAMP || m_mode == M_HOLD);
   endfunction

   task automatic model_edge(input bit acc, input bit es, input int dc, input int d);
      bit t, rev;
      t   = m_tick_now();
      rev = (m_tgt_dir != m_dir) && (m_tgt != 0);
      if (es) begin
         m_duty = 0; m_mode = M_IDLE; m_tgt = 0; m_tgt_dir = 0; m_acc = 0;
      end else begin
         case (m_mode)
            M_IDLE: if (t && m_tgt != 0) begin m_dir = m_tgt_dir; m_mode = M_RAMP; end
            M_RAMP: begin
               if (rev) m_mode = M_REV;
               else if (t) begin
                  if (m_tgt > m_duty) m_duty = (m_duty + STEP < m_tgt) ? m_duty + STEP : m_tgt;
                  else                m_duty = (m_duty - STEP > m_tgt) ? m_duty - STEP : m_tgt;
                  if (m_duty == m_tgt) m_mode = (m_tgt != 0) ? M_HOLD : M_IDLE;
               end
            end
            M_HOLD: if (m_acc) m_mode = rev ? M_REV : M_RAMP;
            M_REV: begin
               if (t) begin
                  m_duty = (m_duty > STEP) ? m_duty - STEP : 0;
                  if (m_duty == 0) begin
`ifdef PWM_RAMP_DEADTIME_EN
                     m_mode = M_DEAD; m_dead_left = 2;
`else
                     m_dir = 1 - m_dir; m_mode = M_RAMP;
`endif
                  end
               end
            end
            M_DEAD: begin
               if (t) begin
                  m_dead_left--;
                  if (m_dead_left == 0) begin m_dir = 1 - m_dir; m_mode = M_RAMP; end
               end
            end
            default: m_mode = M_IDLE;
         endcase
         m_acc = acc;
         if (acc) begin m_tgt = dc; m_tgt_dir = d; end
      end
      m_n++;
   endtask

   task automatic check_outputs(input bit es);
      check_eq("duty", duty, m_duty);
      check_eq("dir", dir, m_dir);
      check_eq("en", en, (m_duty != 0) || m_mode == M_RAMP || m_mode == M_REV);
      check_eq("busy", busy, m_mode == M_RAMP || m_mode == M_REV || m_mode == M_DEAD);
      check_eq("rdy", tgt_rdy, m_rdy(es));
      check_eq("tick", period_tick, m_tick_now());
   endtask

   // One clock: drive at the negedge, check settled outputs, step the model at posedge.
   task automatic cyc(input bit vld, input int dc, input bit d, input bit es);
      bit acc;
      tgt_vld = vld; tgt_dc = W'(dc); tgt_dir = d; estop = es;
      #1;
      check_outputs(es);
      acc = vld && m_rdy(es);
      if (acc) $display("cmd accepted: dc=%0d dir=%0d edge=%0d", dc, d, m_n);
      @(posedge clk);
      model_edge(acc, es, dc, d);
      @(negedge clk);
      if (int'(duty) < g_min_duty) g_min_duty = int'(duty);
      if (duty == 8'd80 && !busy) g_saw_hold80 = 1'b1;
   endtask

   task automatic settle(input int max);
      int k;
      k = 0;
      repeat (2) cyc(0, 0, 0, 0);
      while (!(m_mode == M_HOLD || (m_mode == M_IDLE && m_tgt == 0)) && k < max) begin
         cyc(0, 0, 0, 0);
         k++;
      end
      check_eq("settle_timeout", k >= max, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst = 1'b1; tgt_dc = '0; tgt_dir = 1'b0; tgt_vld = 1'b0; estop = 1'b0;
      model_reset();
      g_min_duty = 255; g_saw_hold80 = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_duty", duty, 0);
      check_eq("rst_dir", dir, 0);
      check_eq("rst_en", en, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rdy", tgt_rdy, 0);
      check_eq("rst_tick", period_tick, 0);
      rst = 1'b0;

      // Ramp up from zero to 200, then hold.
      repeat (3) cyc(0, 0, 0, 0);
      cyc(1, 200, 0, 0);
      settle(80 * PERIOD);
      check_eq("hold200_duty", duty, 200);
      check_eq("hold200_busy", busy, 0);

      // Same-direction ramp down to 50, must clamp and never undershoot.
      g_min_duty = 255;
      cyc(1, 50, 0, 0);
      settle(80 * PERIOD);
      check_eq("hold50_duty", duty, 50);
      check_eq("min_duty_50", g_min_duty, 50);

      // Reversal at 100: ramp to zero, switch direction, ramp back to 100.
      cyc(1, 100, 0, 0);
      settle(80 * PERIOD);
      cyc(1, 100, 1, 0);
      settle(80 * PERIOD);
      check_eq("rev_dir", dir, 1);
      check_eq("rev_duty", duty, 100);
      check_eq("rev_rdy", tgt_rdy, 1);

      // ESTOP mid-ramp at duty 60.
      cyc(1, 20, 1, 0);
      k = 0;
      while (m_duty != 60 && k < 30 * PERIOD) begin cyc(0, 0, 0, 0); k++; end
      check_eq("estop_reach60", duty, 60);
      cyc(0, 0, 0, 1);
      check_eq("estop_duty", duty, 0);
      check_eq("estop_en", en, 0);
      repeat (3) cyc(1, 40, 0, 1);
      cyc(1, 40, 0, 0);
      settle(80 * PERIOD);
      check_eq("post_estop_duty", duty, 40);

      // Asynchronous reset mid-ramp, between clock edges.
      cyc(1, 200, 0, 0);
      repeat (5 * PERIOD) cyc(0, 0, 0, 0);
      tgt_vld = 1'b0; estop = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_duty", duty, 0);
      check_eq("arst_en", en, 0);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_rdy", tgt_rdy, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      k = 0;
      while (period_tick !== 1'b1 && k < 2 * PERIOD) begin cyc(0, 0, 0, 0); k++; end
      check_eq("first_tick_latency", k, PERIOD);

      // Back-to-back commands: the later one wins, no stop at the first target.
      g_saw_hold80 = 1'b0;
      cyc(1, 80, 0, 0);
      cyc(1, 120, 0, 0);
      settle(80 * PERIOD);
      check_eq("b2b_duty", duty, 120);
      check_eq("b2b_no_hold80", g_saw_hold80, 0);

      // Randomized commands, reversals and occasional emergency stops.
      begin
         int gap, es_left, p_dc;
         bit pend, p_d, es, will_acc;
         gap = 0; es_left = 0; pend = 0; p_dc = 0; p_d = 0;
         for (int i = 0; i < 15000; i++) begin
            es = 1'b0;
            if (es_left > 0) begin es = 1'b1; es_left--; end
            else if ($urandom_range(0, 2999) == 0) es_left = $urandom_range(1, 4);
            if (!pend) begin
               if (gap == 0) begin
                  pend = 1'b1;
                  case ($urandom_range(0, 7))
                     0: p_dc = 0;
                     1: p_dc = 255;
                     default: p_dc = $urandom_range(1, 254);
                  endcase
                  p_d = 1'($urandom_range(0, 1));
                  gap = $urandom_range(1, 2500);
               end else begin
                  gap--;
               end
            end
            will_acc = pend && m_rdy(es);
            cyc(pend, p_dc, p_d, es);
            if (will_acc) pend = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
